// File: rtl/sum_sq_feeder.sv
// Vector-magnitude front end: squares |x| and |y| with a 16-cycle serial shift-add,
// hands x^2 + y^2 to the square-root unit and captures the returned root as the magnitude.
module sum_sq_feeder (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] x,
    input  logic signed [15:0] y,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [31:0]        sq_out,
    output logic               sq_go,
    input  logic               sq_done,
    input  logic [31:0]        sq_root,
    output logic [15:0]        mag,
    output logic               mag_valid
);

    typedef enum logic [1:0] {IDLE, MUL, ADD, FEED} state_t;

    state_t      state, state_nx;
    logic [15:0] ax, ay, ax_nx, ay_nx;
    logic [31:0] px, py, px_nx, py_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] sq_out_nx;
    logic        sq_go_nx;
    logic [15:0] mag_nx;
    logic        mag_valid_nx;
    logic        unused_root_hi;

    // Magnitude of a 16-bit two's-complement value; -32768 maps to 0x8000.
    function automatic logic [15:0] abs16(input logic signed [15:0] v);
        logic signed [15:0] neg;
        neg   = -v;
        abs16 = v[15] ? neg : v;
    endfunction

    // Shift-add partial product for multiplier bit k of a*a.
    function automatic logic [31:0] partial(input logic [15:0] a, input logic [3:0] k);
        partial = a[k] ? ({16'd0, a} << k) : 32'd0;
    endfunction

    assign in_ready       = (state == IDLE);
    assign unused_root_hi = ^sq_root[31:16];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        ax_nx        = ax;
        ay_nx        = ay;
        px_nx        = px;
        py_nx        = py;
        cnt_nx       = cnt;
        sq_out_nx    = sq_out;
        sq_go_nx     = sq_go;
        mag_nx       = mag;
        mag_valid_nx = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    ax_nx    = abs16(x);
                    ay_nx    = abs16(y);
                    px_nx    = 32'd0;
                    py_nx    = 32'd0;
                    cnt_nx   = 4'd0;
                    state_nx = MUL;
                end
            end
            MUL: begin
                // Both squares advance one multiplier bit per cycle.
                px_nx  = px + partial(ax, cnt);
                py_nx  = py + partial(ay, cnt);
                cnt_nx = cnt + 4'd1;
                if (cnt == 4'd15) state_nx = ADD;
            end
            ADD: begin
                sq_out_nx = px + py;
                sq_go_nx  = 1'b1;
                state_nx  = FEED;
            end
            FEED: begin
                if (sq_done) begin
                    sq_go_nx     = 1'b0;
                    mag_nx       = sq_root[15:0];
                    mag_valid_nx = 1'b1;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ax        <= '0;
            ay        <= '0;
            px        <= '0;
            py        <= '0;
            cnt       <= '0;
            sq_out    <= '0;
            sq_go     <= 1'b0;
            mag       <= '0;
            mag_valid <= 1'b0;
        end else begin
            ax        <= ax_nx;
            ay        <= ay_nx;
            px        <= px_nx;
            py        <= py_nx;
            cnt       <= cnt_nx;
            sq_out    <= sq_out_nx;
            sq_go     <= sq_go_nx;
            mag       <= mag_nx;
            mag_valid <= mag_valid_nx;
        end
    end

endmodule

// File: tb/tb_sum_sq_feeder.sv
// Directed and random checks of sum_sq_feeder against a behavioural root unit
// (18-cycle done latency) or a hand-driven stub.
module tb_sum_sq_feeder;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] x, y;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        sq_out;
    logic               sq_go;
    logic               sq_done;
    logic [31:0]        sq_root;
    logic [15:0]        mag;
    logic               mag_valid;

    logic        use_model = 1'b1;
    logic        s_done    = 1'b0;
    logic [31:0] s_root    = '0;
    logic        m_done    = 1'b0;
    logic [31:0] m_root    = '0;
    int          m_cnt     = 0;

    int n_chk = 0;
    int n_err = 0;
    int n_acc = 0;
    int mv_count = 0;

    always #5 clk = ~clk;

    assign sq_done = use_model ? m_done : s_done;
    assign sq_root = use_model ? m_root : s_root;

    sum_sq_feeder dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .in_valid(in_valid),
        .in_ready(in_ready), .sq_out(sq_out), .sq_go(sq_go), .sq_done(sq_done),
        .sq_root(sq_root), .mag(mag), .mag_valid(mag_valid)
    );

    function automatic longint isqrt(input longint v);
        longint r = 0;
        for (int b = 15; b >= 0; b--) begin
            longint t = r | (64'sd1 <<< b);
            if (t * t <= v) r = t;
        end
        return r;
    endfunction

    // Root unit: done rises 18 sampled go cycles after go, held until go falls.
    always @(posedge clk) begin
        if (!sq_go) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (!m_done) begin
            if (m_cnt == 17) begin
                m_done <= 1'b1;
                m_root <= 32'(isqrt(longint'(sq_out)));
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) if (mag_valid) mv_count <= mv_count + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Handshake one vector; returns at the negedge after acceptance edge T+16.
    task automatic send(input logic signed [15:0] vx, input logic signed [15:0] vy);
        for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        x = vx; y = vy; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; x = '0; y = '0;
        check_eq("in_ready_busy", 32'(in_ready), 32'd0);
        repeat (16) @(negedge clk);
        check_eq("sq_go_early", 32'(sq_go), 32'd0);
        n_acc++;
    endtask

    task automatic expect_sq(input logic [31:0] exp);
        @(negedge clk);
        check_eq("sq_go", 32'(sq_go), 32'd1);
        check_eq("sq_out", sq_out, exp);
    endtask

    task automatic expect_mag(input logic [15:0] exp);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (mag_valid) found = 1'b1;
        end
        check_eq("mag_valid_seen", 32'(found), 32'd1);
        check_eq("mag", 32'(mag), 32'(exp));
    endtask

    initial begin
        logic signed [15:0] rx, ry;
        longint             sq;
        bit                 held;
        int                 mv0;

        reset = 1'b1; x = '0; y = '0; in_valid = 1'b0;
        #1;
        check_eq("rst_sq_out", sq_out, 32'd0);
        check_eq("rst_sq_go", 32'(sq_go), 32'd0);
        check_eq("rst_mag", 32'(mag), 32'd0);
        check_eq("rst_mag_valid", 32'(mag_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic, extreme negative, back-to-back and zero vectors
        send(16'sd3, 16'sd4);           expect_sq(32'd25);          expect_mag(16'd5);
        send(-16'sd32768, -16'sd32768); expect_sq(32'h8000_0000);   expect_mag(16'd46340);
        send(-16'sd1, 16'sd0);          expect_sq(32'd1);           expect_mag(16'd1);
        send(16'sd0, 16'sd0);           expect_sq(32'd0);           expect_mag(16'd0);
        repeat (3) @(negedge clk);
        #1 check_eq("pulse_count_directed", 32'(mv_count), 32'(n_acc));

        // Stubbed root: done during ADD is ignored, then a long stall
        use_model = 1'b0;
        send(16'sd12, 16'sd5);
        s_done = 1'b1;
        @(negedge clk);
        s_done = 1'b0;
        check_eq("stub_sq_go", 32'(sq_go), 32'd1);
        check_eq("stub_sq_out", sq_out, 32'd169);
        mv0 = mv_count;
        held = 1'b1;
        x = 16'sd100; y = 16'sd100; in_valid = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (!sq_go || sq_out != 32'd169 || in_ready) held = 1'b0;
        end
        in_valid = 1'b0; x = '0; y = '0;
        #1 check_eq("stub_held", 32'(held), 32'd1);
        check_eq("stub_no_pulse", 32'(mv_count), 32'(mv0));
        @(negedge clk);
        s_done = 1'b1; s_root = 32'd13;
        @(negedge clk);
        s_done = 1'b0;
        check_eq("stub_mag_valid", 32'(mag_valid), 32'd1);
        check_eq("stub_mag", 32'(mag), 32'd13);
        check_eq("stub_go_drop", 32'(sq_go), 32'd0);
        @(negedge clk);
        check_eq("stub_single_pulse", 32'(mag_valid), 32'd0);
        use_model = 1'b1;

        // Reset mid-MUL aborts the vector
        for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
        x = 16'sd3; y = 16'sd4; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("midrst_sq_out", sq_out, 32'd0);
        check_eq("midrst_sq_go", 32'(sq_go), 32'd0);
        check_eq("midrst_mag", 32'(mag), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        #1 check_eq("midrst_no_pulse", 32'(mv_count), 32'(n_acc));
        check_eq("midrst_go_idle", 32'(sq_go), 32'd0);
        send(16'sd6, 16'sd8); expect_sq(32'd100); expect_mag(16'd10);

        // Random signed vectors
        for (int i = 0; i < 1000; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            sq = longint'(rx) * longint'(rx) + longint'(ry) * longint'(ry);
            send(rx, ry);
            expect_sq(32'(sq));
            expect_mag(16'(isqrt(sq)));
        end
        repeat (3) @(negedge clk);
        #1 check_eq("pulse_count_total", 32'(mv_count), 32'(n_acc));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
